// File: rtl/board_io.sv
// board_io: core reset conditioner, push-button debounce with press/release pulses,
// and LED drive (level or stretched activity). Define BOARD_IO_HEARTBEAT_EN to drive the top LED from a heartbeat.
module board_io #(
  parameter int N_SW         = 4,
  parameter int N_LED        = 8,
  parameter int RST_STAGES   = 2,
  parameter int DBNC_BITS    = 16,
  parameter int STRETCH_BITS = 20,
  parameter int HB_BITS      = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             rst_out_n,
  input  logic [N_SW-1:0]  sw_raw,
  output logic [N_SW-1:0]  sw_db,
  output logic [N_SW-1:0]  sw_press,
  output logic [N_SW-1:0]  sw_release,
  input  logic [N_LED-1:0] act_in,
  input  logic [N_LED-1:0] led_mode,
  input  logic [N_LED-1:0] led_inv,
  output logic [N_LED-1:0] led
);

  if (RST_STAGES < 2 || HB_BITS < 1) begin : g_param_check
    $error("board_io: RST_STAGES must be >= 2 and HB_BITS >= 1");
  end

  logic [RST_STAGES-1:0]   rst_chain_q, rst_chain_d;
  logic [N_SW-1:0]         sw_s1_q, sw_s2_q;
  logic [N_SW-1:0]         sw_db_q, sw_db_d;
  logic [N_SW-1:0]         sw_press_q, sw_press_d;
  logic [N_SW-1:0]         sw_release_q, sw_release_d;
  logic [DBNC_BITS-1:0]    dbnc_cnt_q [N_SW];
  logic [DBNC_BITS-1:0]    dbnc_cnt_d [N_SW];
  logic [N_LED-1:0]        act_s1_q, act_s2_q, act_dly_q;
  logic [STRETCH_BITS-1:0] str_cnt_q [N_LED];
  logic [STRETCH_BITS-1:0] str_cnt_d [N_LED];
  logic [N_LED-1:0]        led_val_q, led_val_d;
  logic [N_SW-1:0]         s_sw;
  logic [N_LED-1:0]        act_edge;

`ifdef BOARD_IO_HEARTBEAT_EN
  logic [HB_BITS-1:0] hb_cnt_q, hb_cnt_d;
  always_comb hb_cnt_d = rst_out_n ? hb_cnt_q + 1'b1 : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hb_cnt_q <= '0;
    else        hb_cnt_q <= hb_cnt_d;
  end
`endif

  always_comb begin
    rst_chain_d = {rst_chain_q[RST_STAGES-2:0], 1'b1};
    s_sw        = ~sw_s2_q;
    act_edge    = act_s2_q ^ act_dly_q;
  end

  // Counter only advances while the synced input disagrees with the debounced state.
  always_comb begin
    sw_db_d      = sw_db_q;
    sw_press_d   = '0;
    sw_release_d = '0;
    for (int unsigned i = 0; i < N_SW; i++) begin
      dbnc_cnt_d[i] = '0;
      if (s_sw[i] != sw_db_q[i]) begin
        if (dbnc_cnt_q[i] == '1) begin
          sw_db_d[i]      = s_sw[i];
          sw_press_d[i]   = s_sw[i];
          sw_release_d[i] = ~s_sw[i];
        end else begin
          dbnc_cnt_d[i] = dbnc_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    led_val_d = '0;
    for (int unsigned i = 0; i < N_LED; i++) begin
      if (act_edge[i])               str_cnt_d[i] = '1;
      else if (str_cnt_q[i] != '0)   str_cnt_d[i] = str_cnt_q[i] - 1'b1;
      else                           str_cnt_d[i] = '0;
      led_val_d[i] = led_mode[i] ? (str_cnt_q[i] != '0) : act_s2_q[i];
    end
`ifdef BOARD_IO_HEARTBEAT_EN
    led_val_d[N_LED-1] = hb_cnt_q[HB_BITS-1];
`endif
  end

  // Button synchronisers reset to released so reset exit never looks like a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_chain_q  <= '0;
      sw_s1_q      <= '1;
      sw_s2_q      <= '1;
      sw_db_q      <= '0;
      sw_press_q   <= '0;
      sw_release_q <= '0;
      dbnc_cnt_q   <= '{default: '0};
      act_s1_q     <= '0;
      act_s2_q     <= '0;
      act_dly_q    <= '0;
      str_cnt_q    <= '{default: '0};
      led_val_q    <= '0;
    end else begin
      rst_chain_q  <= rst_chain_d;
      sw_s1_q      <= sw_raw;
      sw_s2_q      <= sw_s1_q;
      sw_db_q      <= sw_db_d;
      sw_press_q   <= sw_press_d;
      sw_release_q <= sw_release_d;
      dbnc_cnt_q   <= dbnc_cnt_d;
      act_s1_q     <= act_in;
      act_s2_q     <= act_s1_q;
      act_dly_q    <= act_s2_q;
      str_cnt_q    <= str_cnt_d;
      led_val_q    <= led_val_d;
    end
  end

  assign rst_out_n  = rst_chain_q[RST_STAGES-1];
  assign sw_db      = sw_db_q;
  assign sw_press   = sw_press_q;
  assign sw_release = sw_release_q;
  assign led        = led_val_q ^ led_inv;

endmodule
